// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one held instruction for decode, branch redirect.
// Outputs are decoded from registered state only; decode backpressure holds the instruction in place.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        take_branch,
   input  logic [31:0] branch_target,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        misalign_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic        mis_q, mis_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      mis_d   = 1'b0;
      if (take_branch) begin
         // Redirect wins over everything; an accepted or in-flight request must be drained.
         pc_d  = {branch_target[31:2], 2'b00};
         mis_d = (branch_target[1:0] != 2'b00);
         case (state_q)
            S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
            S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
            S_DRAIN: state_d = S_DRAIN;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  inst_d  = imem_rsp_data;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + 32'd4;
                  state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               if (inst_ready) state_d = S_REQ;
            end
            S_DRAIN: begin
               if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
         ipc_q   <= 32'd0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         mis_q   <= mis_d;
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == S_HOLD);
   assign inst_out       = inst_q;
   assign inst_pc        = ipc_q;
   assign misalign_err   = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level reference model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        take_branch;
   logic [31:0] branch_target;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        misalign_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: started = out of the post-reset idle cycle; out = a request is in flight;
   // disc = the in-flight response is to be thrown away; have = an instruction is held.
   logic        m_started, m_out, m_disc, m_have, m_mis;
   logic [31:0] m_pc, m_inst, m_ipc;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .take_branch(take_branch), .branch_target(branch_target),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, m_started && !m_out && !m_have});
      chk({tag, ".req_addr"},  imem_req_addr, m_pc);
      chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, m_have});
      chk({tag, ".inst_out"},  inst_out, m_inst);
      chk({tag, ".inst_pc"},   inst_pc, m_ipc);
      chk({tag, ".misalign"},  {31'd0, misalign_err}, {31'd0, m_mis});
   endtask

   task automatic model_reset();
      m_started = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_have = 1'b0; m_mis = 1'b0;
      m_pc = 32'h0000_0000; m_inst = 32'd0; m_ipc = 32'd0;
   endtask

   task automatic step(input string tag, input logic rst, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic rsp, input logic [31:0] dat, input logic irdy);
      logic acc;
      logic arr;
      rst_n = rst; take_branch = br; branch_target = tgt;
      imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rsp_data = dat; inst_ready = irdy;
      if (!rst) begin
         model_reset();
      end else begin
         acc   = m_started && !m_out && !m_have && rdy;
         arr   = m_out && rsp;
         m_mis = br && (tgt[1:0] != 2'b00);
         if (br) begin
            if (!(m_out && m_disc)) m_out = (m_out && !arr) || acc;
            m_disc    = m_out;
            m_have    = 1'b0;
            m_started = 1'b1;
            m_pc      = {tgt[31:2], 2'b00};
         end else if (!m_started) begin
            m_started = 1'b1;
         end else if (m_have) begin
            if (irdy) m_have = 1'b0;
         end else if (m_out) begin
            if (rsp) begin
               if (!m_disc) begin
                  m_have = 1'b1; m_inst = dat; m_ipc = m_pc; m_pc = m_pc + 32'd4;
               end
               m_out  = 1'b0;
               m_disc = 1'b0;
            end
         end else if (rdy) begin
            m_out  = 1'b1;
            m_disc = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   initial begin
      logic        r_br, r_rdy, r_rsp, r_irdy, r_rst;
      logic [31:0] r_tgt;
      rst_n = 1'b0; take_branch = 1'b0; branch_target = 32'd0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; inst_ready = 1'b0;
      model_reset();

      // Reset, including a branch request that must be ignored.
      step("rst0", 0, 0, 32'h0, 1, 0, 32'h0, 0);
      step("rst1", 0, 1, 32'h300, 1, 1, 32'hDEAD_BEEF, 1);
      chk("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);

      // First fetch after reset release.
      step("idle", 1, 0, 32'h0, 1, 0, 32'h0, 1);
      chk("first.req", {31'd0, imem_req_valid}, 32'd1);
      chk("first.addr", imem_req_addr, 32'h0);
      step("f0.acc", 1, 0, 32'h0, 1, 0, 32'h0, 1);
      step("f0.rsp", 1, 0, 32'h0, 0, 1, 32'h0050_0093, 1);
      chk("f0.inst", inst_out, 32'h0050_0093);
      chk("f0.pc", inst_pc, 32'h0);
      step("f0.take", 1, 0, 32'h0, 0, 0, 32'h0, 1);
      chk("f1.addr", imem_req_addr, 32'h4);

      // Decode stalls for 5 cycles.
      step("st.acc", 1, 0, 32'h0, 1, 0, 32'h0, 0);
      step("st.rsp", 1, 0, 32'h0, 0, 1, 32'h1234_5678, 0);
      for (int i = 0; i < 5; i++) step("st.hold", 1, 0, 32'h0, 1, (i == 2), 32'hBAD0_0000, 0);
      step("st.go", 1, 0, 32'h0, 0, 0, 32'h0, 1);
      chk("st.next", imem_req_addr, 32'h8);

      // Redirect in WAIT, late response drained.
      step("dr.acc", 1, 0, 32'h0, 1, 0, 32'h0, 1);
      step("dr.br", 1, 1, 32'h100, 0, 0, 32'h0, 1);
      step("dr.wait", 1, 0, 32'h0, 1, 0, 32'h0, 1);
      step("dr.rsp", 1, 0, 32'h0, 0, 1, 32'hFFFF_0000, 1);
      chk("dr.addr", imem_req_addr, 32'h100);
      chk("dr.nodeliv", {31'd0, inst_valid}, 32'd0);

      // Redirect in HOLD while decode is ready.
      step("hb.acc", 1, 0, 32'h0, 1, 0, 32'h0, 0);
      step("hb.rsp", 1, 0, 32'h0, 0, 1, 32'h0000_0013, 0);
      step("hb.br", 1, 1, 32'h200, 0, 0, 32'h0, 1);
      chk("hb.addr", imem_req_addr, 32'h200);

      // Misaligned redirect.
      step("mis.br", 1, 1, 32'h103, 0, 0, 32'h0, 1);
      chk("mis.addr", imem_req_addr, 32'h100);
      chk("mis.hi", {31'd0, misalign_err}, 32'd1);
      step("mis.lo", 1, 0, 32'h0, 0, 0, 32'h0, 1);
      chk("mis.lo1", {31'd0, misalign_err}, 32'd0);

      // PC wrap, then reset in WAIT.
      step("wr.br", 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1);
      step("wr.acc", 1, 0, 32'h0, 1, 0, 32'h0, 1);
      step("wr.rsp", 1, 0, 32'h0, 0, 1, 32'hAAAA_5555, 1);
      chk("wr.ipc", inst_pc, 32'hFFFF_FFFC);
      step("wr.take", 1, 0, 32'h0, 0, 0, 32'h0, 1);
      chk("wr.addr", imem_req_addr, 32'h0);
      step("wr.acc2", 1, 0, 32'h0, 1, 0, 32'h0, 1);
      step("wr.rst", 0, 0, 32'h0, 0, 0, 32'h0, 1);
      chk("wr.rstpc", imem_req_addr, 32'h0);
      chk("wr.rstvld", {31'd0, imem_req_valid}, 32'd0);

      // Randomized traffic with occasional protocol-violating responses and resets.
      for (int i = 0; i < 4000; i++) begin
         r_rst  = ($urandom_range(0, 199) != 0);
         r_br   = ($urandom_range(0, 11) == 0);
         r_tgt  = $urandom;
         if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | {28'd0, r_tgt[3:0]};
         r_rdy  = ($urandom_range(0, 2) != 0);
         r_irdy = ($urandom_range(0, 2) != 0);
         if (m_out) r_rsp = ($urandom_range(0, 2) == 0);
         else       r_rsp = ($urandom_range(0, 49) == 0);
         // A branch in DRAIN coincident with the drained response would strand the fetcher.
         if (m_out && m_disc && r_br) r_rsp = 1'b0;
         step("rnd", r_rst, r_br, r_tgt, r_rdy, r_rsp, $urandom, r_irdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
